// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined barrel shifter:
//   - shift_mode_e : operation encodings (LSL, LSR, ASR, reserved)
//   - shift_ctrl_t : per-stage control payload (valid, lost, ovr, sign, mode)
//   - clog2()      : elaboration-time ceil(log2(value))
// Data and tag ride next to shift_ctrl_t rather than inside it because
// their widths are set by each instance's parameters.
// ---------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSL  = 2'b00,
        MODE_LSR  = 2'b01,
        MODE_ASR  = 2'b10,
        MODE_RSVD = 2'b11
    } shift_mode_e;

    typedef struct packed {
        logic        valid;  // stage holds a live transaction
        logic        lost;   // OR of every 1-bit dropped so far
        logic        ovr;    // shift amount >= WIDTH
        logic        sign;   // original operand MSB, used as ASR fill
        shift_mode_e mode;   // reserved encoding already folded to LSR
    } shift_ctrl_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_level.sv
// ---------------------------------------------------------------------------
// shift_level
// One mux level of the barrel shifter: shifts by DIST when sel is set,
// inserting the mode's fill and OR-ing the dropped bits into the lost flag.
// The final level (LAST) also applies the oversize override. When
// REGISTERED is set the result is captured in an enable-gated register.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   en           : pipeline advance; register loads only when set
//   sel          : shift-amount bit for this level
//   in_ctrl/data/pass  : incoming payload (pass = tag + amount bits)
//   out_ctrl/data/pass : outgoing payload
// ---------------------------------------------------------------------------
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int DIST       = 1,
    parameter bit REGISTERED = 1'b1,
    parameter bit LAST       = 1'b0,
    parameter int PASS_W     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sel,
    input  shift_ctrl_t       in_ctrl,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [PASS_W-1:0] in_pass,
    output shift_ctrl_t       out_ctrl,
    output logic [WIDTH-1:0]  out_data,
    output logic [PASS_W-1:0] out_pass
);

    shift_ctrl_t      nxt_ctrl;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt_data;
    logic             dropped_any;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        shifted     = in_data;
        dropped_any = 1'b0;
        if (sel) begin
            unique case (in_ctrl.mode)
                MODE_LSL: begin
                    shifted     = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                    dropped_any = |in_data[WIDTH-1 -: DIST];
                end
                MODE_ASR: begin
                    // Fill from the carried original sign; sign copies are
                    // never counted as lost.
                    shifted     = {{DIST{in_ctrl.sign}}, in_data[WIDTH-1:DIST]};
                    dropped_any = |in_data[DIST-1:0];
                end
                default: begin
                    shifted     = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
                    dropped_any = |in_data[DIST-1:0];
                end
            endcase
        end

        nxt_ctrl      = in_ctrl;
        nxt_ctrl.lost = in_ctrl.lost | dropped_any;
        nxt_data      = shifted;

        // Every original bit is now either dropped (already in lost) or
        // still in the word, so lost | (|word) equals |original operand.
        // Sign fill only appears when the operand's MSB was 1, which keeps
        // that identity true for ASR as well.
        if (LAST && in_ctrl.ovr) begin
            nxt_data      = (in_ctrl.mode == MODE_ASR) ? {WIDTH{in_ctrl.sign}} : '0;
            nxt_ctrl.lost = nxt_ctrl.lost | (|shifted);
        end
    end

    if (REGISTERED) begin : g_reg
        shift_ctrl_t       ctrl_q;
        logic [WIDTH-1:0]  data_q;
        logic [PASS_W-1:0] pass_q;

        // NOTE: the datapath fields are reset along with valid so a freshly
        // reset output shows zero data, lost and tag, not leftover values.
        // NOTE: state updates use non-blocking assignments so every stage
        // samples its predecessor's pre-edge value.
        always_ff @(posedge clk) begin
            if (reset) begin
                ctrl_q <= '0;
                data_q <= '0;
                pass_q <= '0;
            end else if (en) begin
                ctrl_q <= nxt_ctrl;
                data_q <= nxt_data;
                pass_q <= in_pass;
            end
        end

        assign out_ctrl = ctrl_q;
        assign out_data = data_q;
        assign out_pass = pass_q;
    end else begin : g_comb
        logic unused_clk_en;
        assign unused_clk_en = ^{clk, reset, en};

        assign out_ctrl = nxt_ctrl;
        assign out_data = nxt_data;
        assign out_pass = in_pass;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
// Pipelined LSL / LSR / ASR barrel shifter with a sticky lost-bits flag and
// a sideband tag, built from LEVELS = clog2(WIDTH) shift_level instances.
// A register follows every REG_EVERY levels and always the last one.
// All stages advance together: adv = !out_valid || out_ready.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   in_valid/in_ready              : input handshake
//   in_data, in_amt, in_mode, in_tag : operand, amount, mode, sideband tag
//   out_valid/out_ready            : output handshake
//   out_data, out_lost, out_tag    : result, lost-bits flag, tag
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int SHAMT_W   = 8,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_lost,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LEVELS  = clog2(WIDTH);
    // Pass-through field: tag on top, the LEVELS low amount bits below.
    localparam int PASS_W  = TAG_W + LEVELS;
    localparam int AMT_EXT = (SHAMT_W > 32) ? SHAMT_W : 32;

    logic              adv;
    logic [AMT_EXT-1:0] amt_ext;
    shift_ctrl_t       ctrl_0;
    logic [PASS_W-1:0] pass_0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Amount bits above LEVELS matter only through this comparison.
    assign amt_ext = AMT_EXT'(in_amt);

    always_comb begin
        ctrl_0       = '0;
        ctrl_0.valid = in_valid;
        ctrl_0.ovr   = (amt_ext >= AMT_EXT'(WIDTH));
        ctrl_0.sign  = in_data[WIDTH-1];
        ctrl_0.mode  = (in_mode == MODE_RSVD) ? MODE_LSR : shift_mode_e'(in_mode);
    end

    assign pass_0 = {in_tag, LEVELS'(in_amt)};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        shift_ctrl_t       ctrl_i;
        shift_ctrl_t       ctrl_o;
        logic [WIDTH-1:0]  data_i;
        logic [WIDTH-1:0]  data_o;
        logic [PASS_W-1:0] pass_i;
        logic [PASS_W-1:0] pass_o;

        if (k == 0) begin : g_first
            assign ctrl_i = ctrl_0;
            assign data_i = in_data;
            assign pass_i = pass_0;
        end else begin : g_next
            assign ctrl_i = g_lvl[k-1].ctrl_o;
            assign data_i = g_lvl[k-1].data_o;
            assign pass_i = g_lvl[k-1].pass_o;
        end

        shift_level #(
            .WIDTH      (WIDTH),
            .DIST       (1 << k),
            .REGISTERED (((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1)),
            .LAST       (k == LEVELS - 1),
            .PASS_W     (PASS_W)
        ) u_level (
            .clk      (clk),
            .reset    (reset),
            .en       (adv),
            .sel      (pass_i[k]),
            .in_ctrl  (ctrl_i),
            .in_data  (data_i),
            .in_pass  (pass_i),
            .out_ctrl (ctrl_o),
            .out_data (data_o),
            .out_pass (pass_o)
        );
    end

    assign out_valid = g_lvl[LEVELS-1].ctrl_o.valid;
    assign out_lost  = g_lvl[LEVELS-1].ctrl_o.lost;
    assign out_data  = g_lvl[LEVELS-1].data_o;
    assign out_tag   = g_lvl[LEVELS-1].pass_o[PASS_W-1 -: TAG_W];

    // Control fields that have done their job by the last level.
    logic unused_tail;
    assign unused_tail = ^{g_lvl[LEVELS-1].ctrl_o.ovr,
                           g_lvl[LEVELS-1].ctrl_o.sign,
                           g_lvl[LEVELS-1].ctrl_o.mode,
                           g_lvl[LEVELS-1].pass_o[LEVELS-1:0]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Two instances: dut (REG_EVERY=1) and dut2 (REG_EVERY=2). Expected results
// come from ref_shift(), which computes the shift with wide arithmetic.
// Each instance has a scoreboard queue filled on accept and checked every
// cycle its output is valid.
// ---------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

    localparam int W  = 24;
    localparam int SW = 8;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          in_valid, in_ready, out_valid, out_ready, out_lost;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] in_amt;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag, out_tag;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_lost;
    logic [W-1:0]  b_in_data, b_out_data;
    logic [SW-1:0] b_in_amt;
    logic [1:0]    b_in_mode;
    logic [TW-1:0] b_in_tag, b_out_tag;

    pipelined_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW), .REG_EVERY(1), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lost(out_lost), .out_tag(out_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW), .REG_EVERY(2), .TAG_W(TW)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_lost(b_out_lost), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic          lost;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out1   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {lost, result}.
    function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] a,
                                             input logic [1:0] m);
        logic [2*W-1:0] wide;
        logic [W-1:0]   r;
        logic           l;
        if (int'(a) >= W) begin
            r = (m == 2'b10 && d[W-1]) ? '1 : '0;
            l = |d;
        end else if (m == 2'b00) begin
            wide = {{W{1'b0}}, d} << a;
            r    = wide[W-1:0];
            l    = |wide[2*W-1:W];
        end else begin
            wide = {d, {W{1'b0}}} >> a;
            r    = wide[2*W-1:W];
            l    = |wide[W-1:0];
            if (m == 2'b10 && d[W-1]) r = r | ~({W{1'b1}} >> a);
        end
        return {l, r};
    endfunction

    function automatic exp_t mk(input logic [W-1:0] d, input logic [SW-1:0] a,
                                input logic [1:0] m, input logic [TW-1:0] t);
        logic [W:0] res;
        exp_t e;
        res    = ref_shift(d, a, m);
        e.data = res[W-1:0];
        e.lost = res[W];
        e.tag  = t;
        return e;
    endfunction

    // Compare process for dut: on every cycle out_valid is high the head of
    // the scoreboard must be on the output; it leaves the queue when consumed.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
        end else begin
            if (out_valid) begin
                check("out_valid_with_pending", 64'(out_valid), 64'(q1.size() != 0));
                if (q1.size() != 0) begin
                    check("out_data", 64'(out_data), 64'(q1[0].data));
                    check("out_lost", 64'(out_lost), 64'(q1[0].lost));
                    check("out_tag",  64'(out_tag),  64'(q1[0].tag));
                    if (out_ready) begin
                        void'(q1.pop_front());
                        n_out1++;
                    end
                end
            end
            if (in_valid && in_ready) q1.push_back(mk(in_data, in_amt, in_mode, in_tag));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            q2.delete();
        end else begin
            if (b_out_valid) begin
                check("out_valid_with_pending2", 64'(b_out_valid), 64'(q2.size() != 0));
                if (q2.size() != 0) begin
                    check("out_data2", 64'(b_out_data), 64'(q2[0].data));
                    check("out_lost2", 64'(b_out_lost), 64'(q2[0].lost));
                    check("out_tag2",  64'(b_out_tag),  64'(q2[0].tag));
                    if (b_out_ready) void'(q2.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) q2.push_back(mk(b_in_data, b_in_amt, b_in_mode, b_in_tag));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one op to dut and hold it until accepted (bounded).
    task automatic send1(input logic [W-1:0] d, input logic [SW-1:0] a,
                         input logic [1:0] m, input logic [TW-1:0] t);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accepted", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single op into an empty pipeline; cycles counted from the presenting
    // cycle to the first cycle with out_valid.
    task automatic lat(input bit which, input logic [W-1:0] d, input logic [SW-1:0] a,
                       input logic [1:0] m, input logic [TW-1:0] t, input int exp_lat);
        int cyc;
        cyc = 0;
        if (!which) begin
            in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_tag = t;
        end else begin
            b_in_valid = 1'b1; b_in_data = d; b_in_amt = a; b_in_mode = m; b_in_tag = t;
        end
        @(negedge clk);
        check("lat_accept", 64'(which ? b_in_ready : in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(which ? b_out_valid : out_valid) && cyc < 20);
        check(which ? "latency2" : "latency", 64'(cyc), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit which);
        int n;
        n = 0;
        while (((which ? q2.size() : q1.size()) != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(which ? "drained2" : "drained", 64'(which ? q2.size() : q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: data, amt, mode, tag, hand-computed result and lost.
    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] a;
        logic [1:0]    m;
        logic [TW-1:0] t;
        logic [W-1:0]  r;
        logic          l;
    } vec_t;

    vec_t vecs[8] = '{
        '{24'h800001, 8'd1,   2'b01, 4'hA, 24'h400000, 1'b1},
        '{24'h800000, 8'd4,   2'b10, 4'h1, 24'hF80000, 1'b0},
        '{24'h7FFFF0, 8'd4,   2'b10, 4'h2, 24'h07FFFF, 1'b0},
        '{24'h000003, 8'd23,  2'b00, 4'h3, 24'h800000, 1'b1},
        '{24'h000001, 8'd0,   2'b00, 4'h4, 24'h000001, 1'b0},
        '{24'h123456, 8'd30,  2'b01, 4'h5, 24'h000000, 1'b1},
        '{24'h800000, 8'd200, 2'b10, 4'h6, 24'hFFFFFF, 1'b1},
        '{24'h000000, 8'd255, 2'b00, 4'h7, 24'h000000, 1'b0}
    };

    int snap;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0; in_data   = '0; in_amt   = '0; in_mode   = '0; in_tag   = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0; b_in_tag = '0;
        out_ready  = 1'b1;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_lost",  64'(out_lost),  64'd0);
        check("reset_out_tag",   64'(out_tag),   64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pin the reference against the hand-computed table.
        foreach (vecs[i])
            check($sformatf("model_pin_%0d", i), 64'(ref_shift(vecs[i].d, vecs[i].a, vecs[i].m)),
                  64'({vecs[i].l, vecs[i].r}));

        // Directed ops, one at a time; each must take 5 cycles.
        foreach (vecs[i]) lat(1'b0, vecs[i].d, vecs[i].a, vecs[i].m, vecs[i].t, 5);
        drain(1'b0);

        // Eight back-to-back ops with a 3-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send1(W'($urandom), SW'($urandom_range(0, 30)), 2'($urandom), TW'(i));
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(1'b0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = W'($urandom);
            if ($urandom_range(0, 3) == 0) in_data[W-1] = 1'b1;
            in_amt    = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, W - 1));
            in_mode   = 2'($urandom);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(1'b0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) send1(24'hABCDEF, 8'(i + 1), 2'b01, 4'hF);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_data",  64'(out_data),  64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        snap  = n_out1;
        send1(24'h000F00, 8'd4, 2'b00, 4'h9);
        send1(24'hF000F0, 8'd8, 2'b10, 4'h8);
        drain(1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_count", 64'(n_out1 - snap), 64'd2);

        // REG_EVERY=2 instance: 3-cycle latency, then random traffic.
        lat(1'b1, 24'h800001, 8'd1, 2'b01, 4'hA, 3);
        for (int c = 0; c < 150; c++) begin
            b_in_valid  = ($urandom_range(0, 9) < 8);
            b_in_data   = W'($urandom);
            b_in_amt    = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, W - 1));
            b_in_mode   = 2'($urandom);
            b_in_tag    = TW'($urandom);
            b_out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
